rr_mux4_arbiter: RTL and testbench
==================================

Name: rr_mux4_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared 4:1 data multiplexer.
- Four requesters each present a request and a WIDTH-bit data word.
- The block grants one requester at a time, drives the mux select, and forwards that requester's data onto a single valid/ready output channel.
- Grant tenure is capped at MAX_HOLD transferred beats, so no requester can starve the others.

Parameters:
- WIDTH, 8, data width per requester and of the output.
- MAX_HOLD, 4, maximum beats transferred per grant before forced release; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per requester; bit i = requester i.
- in_data  input  4*WIDTH  packed data; requester i occupies bits [i*WIDTH +: WIDTH].
- out_ready  input  1  downstream accepts a beat when high.
- gnt  output  4  one-hot grant, registered; 4'b0000 when idle.
- sel  output  2  registered mux select; equals the index of the granted requester.
- out_data  output  WIDTH  in_data slice selected by sel (combinational mux).
- out_valid  output  1  high when granted and req[sel] is high.
- busy  output  1  high in GRANT state.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, gnt=0, sel=0, rr pointer ptr=0, beat_cnt=0.
  - Outputs while in reset: out_valid=0, busy=0, out_data=in_data[WIDTH-1:0].
- States: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select the first set bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Next edge: gnt=onehot(winner), sel=winner, beat_cnt=0, state=GRANT.
  - Latency: req seen at edge N gives gnt at edge N+1. out_valid can first assert in the cycle after edge N+1.
- GRANT:
  - out_valid = req[sel]; out_data = in_data[sel*WIDTH +: WIDTH].
  - A beat transfers on an edge where out_valid && out_ready; beat_cnt increments on each transfer.
  - Release on the first of the following:
    - a transfer with beat_cnt==MAX_HOLD-1;
    - a cycle with req[sel]==0. Release happens regardless of out_ready; no beat is counted.
  - On release: state=IDLE, gnt=0, ptr=(sel+1) mod 4. sel holds its value.
  - out_ready low with req[sel] high: stay in GRANT, hold state, no count.
- There is a minimum one-cycle IDLE bubble between grants. This is intentional: out_valid is never high across a grant change.
- Requests from non-granted requesters do not affect the current grant.
- A requester that releases and immediately re-requests is searched last, after the other three.
- beat_cnt is 8 bits wide and never exceeds MAX_HOLD-1.
- With MAX_HOLD=1, every transfer releases the grant.
- Reset asserted mid-grant: return to reset values at once. The beat in flight is not counted, and no stall or ready dependency applies.
- out_valid is never high when gnt==0.

Test Plan:
1. Reset then single request: rst_n low 2 cycles, then high; req=4'b0100, out_ready=1, in_data slice 2 = 8'hA5.
   -> gnt=4'b0100 and sel=2 one edge later; out_data=8'hA5 with out_valid=1; release after 4 beats; ptr=3.
2. Round-robin fairness: req=4'b1111 held, out_ready=1.
   -> grant order 0,1,2,3,0. Each tenure is 4 beats followed by 1 IDLE cycle; gnt is always one-hot or zero.
3. Backpressure: requester 1 granted, out_ready low for 3 cycles after the 2nd beat.
   -> gnt stays 4'b0010; beat_cnt holds at 2; release only after 2 more accepted beats.
4. Early drop: requester 0 granted, req[0] deasserts after 1 beat while req[3]=1.
   -> release the next edge; IDLE 1 cycle; then gnt=4'b1000, sel=3.
5. Pointer wrap and skip: after requester 3 releases, req=4'b0110.
   -> next grant is requester 1: the search wraps from ptr=0 and skips 0.
6. Reset mid-grant: rst_n low mid-tenure with out_valid=1.
   -> gnt=0, out_valid=0, busy=0 immediately, without waiting for a clock. After reset, arbitration restarts from ptr=0.

Source files
------------

// File: rtl/rr_mux4_arbiter.sv
// rr_mux4_arbiter
//   Round-robin arbiter and sequencer for a shared 4:1 data multiplexer.
//   Four requesters present req[i] and a WIDTH-bit word. One requester is
//   granted at a time. Its word is forwarded on a single valid/ready channel.
//   A grant is held for at most MAX_HOLD transferred beats. It is also
//   dropped as soon as the granted requester withdraws its request.
//   At least one IDLE cycle always separates two grants, so out_valid
//   never spans a grant change.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req        in   [3:0]         request per requester
//   in_data    in   [4*WIDTH-1:0] requester i at bits [i*WIDTH +: WIDTH]
//   out_ready  in   downstream accepts a beat when high
//   gnt        out  [3:0]         registered one-hot grant, 0 when idle
//   sel        out  [1:0]         registered mux select (index of grant)
//   out_data   out  [WIDTH-1:0]   in_data slice chosen by sel
//   out_valid  out  high when granted and req[sel] is high
//   busy       out  high while in GRANT
module rr_mux4_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] in_data,
    input  logic               out_ready,
    output logic [3:0]         gnt,
    output logic [1:0]         sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    output logic               busy
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Value of beat_cnt at which the next accepted beat ends the tenure.
    localparam logic [7:0] LAST_BEAT = 8'(MAX_HOLD - 1);

    state_t     state_r, state_s;
    logic [3:0] gnt_r, gnt_s;
    logic [1:0] sel_r, sel_s;
    logic [1:0] ptr_r, ptr_s;
    logic [7:0] beat_cnt_r, beat_cnt_s;
    logic [1:0] winner_s;

    // First set request bit, searching from p upward with wrap-around.
    // The result is only meaningful when r is non-zero.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = p;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = p + 2'(i);
            if (!found && r[idx]) begin
                win   = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

    // Convert a 2-bit index to a one-hot 4-bit grant vector.
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Round-robin winner for the current request vector and pointer.
    always_comb begin
        winner_s = rr_pick(req, ptr_r);
    end

    // Next-state logic. The pointer moves past the released requester, so
    // that requester is searched last next time.
    always_comb begin
        state_s    = state_r;
        gnt_s      = gnt_r;
        sel_s      = sel_r;
        ptr_s      = ptr_r;
        beat_cnt_s = beat_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (req != 4'b0000) begin
                    state_s    = ST_GRANT;
                    gnt_s      = onehot4(winner_s);
                    sel_s      = winner_s;
                    beat_cnt_s = 8'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!req[sel_r]) begin
                    // Requester withdrew: release without counting a beat.
                    state_s    = ST_IDLE;
                    gnt_s      = 4'b0000;
                    ptr_s      = sel_r + 2'd1;
                    beat_cnt_s = 8'd0;
                end else if (out_ready) begin
                    if (beat_cnt_r == LAST_BEAT) begin
                        state_s    = ST_IDLE;
                        gnt_s      = 4'b0000;
                        ptr_s      = sel_r + 2'd1;
                        beat_cnt_s = 8'd0;
                    end else begin
                        beat_cnt_s = beat_cnt_r + 8'd1;
                    end
                end else begin
                    // Stalled by downstream: hold everything.
                    beat_cnt_s = beat_cnt_r;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                gnt_s      = 4'b0000;
                beat_cnt_s = 8'd0;
            end
        endcase
    end

    // State and control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            gnt_r      <= 4'b0000;
            sel_r      <= 2'd0;
            ptr_r      <= 2'd0;
            beat_cnt_r <= 8'd0;
        end else begin
            state_r    <= state_s;
            gnt_r      <= gnt_s;
            sel_r      <= sel_s;
            ptr_r      <= ptr_s;
            beat_cnt_r <= beat_cnt_s;
        end
    end

    // Output decode. It is driven from the registers, so async reset
    // clears out_valid and busy at once.
    always_comb begin
        gnt      = gnt_r;
        sel      = sel_r;
        busy     = (state_r == ST_GRANT);
        out_data = in_data[sel_r*WIDTH +: WIDTH];
        if (state_r == ST_GRANT) begin
            out_valid = req[sel_r];
        end else begin
            out_valid = 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed testbench for rr_mux4_arbiter (WIDTH=8, MAX_HOLD=4).
// Inputs are driven 1 ns after the rising edge. Outputs are checked after
// they settle, away from the clock edge.
module tb_rr_mux4_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] in_data;
    logic        out_ready;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    rr_mux4_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in_data   (in_data),
        .out_ready (out_ready),
        .gnt       (gnt),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req       = 4'b0000;
        out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset_single();
        in_data = {8'h44, 8'hA5, 8'h22, 8'h11};
        rst_n = 1'b0; req = 4'b0000; out_ready = 1'b1;
        tick(); tick();
        n_checks++; if (gnt !== 4'b0000) begin $display("FAIL rst_gnt actual=%b expected=%b", gnt, 4'b0000); n_fail++; end
        n_checks++; if (sel !== 2'd0) begin $display("FAIL rst_sel actual=%0d expected=0", sel); n_fail++; end
        n_checks++; if (busy !== 1'b0) begin $display("FAIL rst_busy actual=%b expected=0", busy); n_fail++; end
        n_checks++; if (out_valid !== 1'b0) begin $display("FAIL rst_valid actual=%b expected=0", out_valid); n_fail++; end
        n_checks++; if (out_data !== 8'h11) begin $display("FAIL rst_data actual=%h expected=11", out_data); n_fail++; end
        rst_n = 1'b1;
        req   = 4'b0100;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin $display("FAIL t1_idle_valid actual=%b expected=0", out_valid); n_fail++; end
        tick();
        n_checks++; if (gnt !== 4'b0100) begin $display("FAIL t1_gnt actual=%b expected=%b", gnt, 4'b0100); n_fail++; end
        n_checks++; if (sel !== 2'd2) begin $display("FAIL t1_sel actual=%0d expected=2", sel); n_fail++; end
        n_checks++; if (out_data !== 8'hA5) begin $display("FAIL t1_data actual=%h expected=a5", out_data); n_fail++; end
        n_checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin $display("FAIL t1_valid_busy actual=%b%b expected=11", out_valid, busy); n_fail++; end
        for (int b = 1; b < 4; b++) begin
            tick();
            n_checks++; if (gnt !== 4'b0100) begin $display("FAIL t1_hold_b%0d actual=%b expected=%b", b, gnt, 4'b0100); n_fail++; end
        end
        tick();
        n_checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin $display("FAIL t1_release actual=%b/%b expected=0000/0", gnt, busy); n_fail++; end
        n_checks++; if (sel !== 2'd2) begin $display("FAIL t1_sel_hold actual=%0d expected=2", sel); n_fail++; end
        // ptr should now be 3: with req 0 and 3 set, 3 wins.
        req = 4'b1001;
        tick();
        n_checks++; if (gnt !== 4'b1000) begin $display("FAIL t1_ptr3 actual=%b expected=%b", gnt, 4'b1000); n_fail++; end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        do_reset();
        req = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            exp_g = 4'b0001 << (k % 4);
            tick();
            n_checks++; if (gnt !== exp_g || sel !== 2'(k % 4)) begin $display("FAIL rr_grant%0d actual=%b/%0d expected=%b/%0d", k, gnt, sel, exp_g, k % 4); n_fail++; end
            for (int b = 1; b < 4; b++) begin
                tick();
                n_checks++; if (gnt !== exp_g || out_valid !== 1'b1) begin $display("FAIL rr_hold%0d_%0d actual=%b/%b expected=%b/1", k, b, gnt, out_valid, exp_g); n_fail++; end
            end
            tick();
            n_checks++; if (gnt !== 4'b0000 || out_valid !== 1'b0) begin $display("FAIL rr_idle%0d actual=%b/%b expected=0000/0", k, gnt, out_valid); n_fail++; end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req = 4'b0010; out_ready = 1'b1;
        tick();
        n_checks++; if (gnt !== 4'b0010) begin $display("FAIL bp_grant actual=%b expected=%b", gnt, 4'b0010); n_fail++; end
        tick(); tick();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++; if (gnt !== 4'b0010 || out_valid !== 1'b1) begin $display("FAIL bp_stall%0d actual=%b/%b expected=0010/1", c, gnt, out_valid); n_fail++; end
        end
        out_ready = 1'b1;
        tick();
        n_checks++; if (gnt !== 4'b0010) begin $display("FAIL bp_beat3 actual=%b expected=%b", gnt, 4'b0010); n_fail++; end
        tick();
        n_checks++; if (gnt !== 4'b0000) begin $display("FAIL bp_release actual=%b expected=%b", gnt, 4'b0000); n_fail++; end
    endtask

    task automatic test_early_drop_and_wrap();
        do_reset();
        req = 4'b1001; out_ready = 1'b1;
        tick();
        n_checks++; if (gnt !== 4'b0001) begin $display("FAIL drop_grant0 actual=%b expected=%b", gnt, 4'b0001); n_fail++; end
        tick();
        req = 4'b1000;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin $display("FAIL drop_valid actual=%b expected=0", out_valid); n_fail++; end
        tick();
        n_checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin $display("FAIL drop_release actual=%b/%b expected=0000/0", gnt, busy); n_fail++; end
        tick();
        n_checks++; if (gnt !== 4'b1000 || sel !== 2'd3) begin $display("FAIL drop_grant3 actual=%b/%0d expected=1000/3", gnt, sel); n_fail++; end
        // Requester 3 withdraws: ptr wraps to 0, search skips 0 and picks 1.
        req = 4'b0110;
        tick();
        n_checks++; if (gnt !== 4'b0000) begin $display("FAIL wrap_release actual=%b expected=%b", gnt, 4'b0000); n_fail++; end
        tick();
        n_checks++; if (gnt !== 4'b0010 || sel !== 2'd1) begin $display("FAIL wrap_grant1 actual=%b/%0d expected=0010/1", gnt, sel); n_fail++; end
        n_checks++; if (out_data !== 8'h22) begin $display("FAIL wrap_data actual=%h expected=22", out_data); n_fail++; end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 4'b0100; out_ready = 1'b1;
        tick();
        tick();
        n_checks++; if (out_valid !== 1'b1) begin $display("FAIL mid_pre_valid actual=%b expected=1", out_valid); n_fail++; end
        rst_n = 1'b0;
        #1;
        n_checks++; if (gnt !== 4'b0000 || out_valid !== 1'b0 || busy !== 1'b0 || sel !== 2'd0) begin $display("FAIL mid_async actual=%b/%b/%b/%0d expected=0000/0/0/0", gnt, out_valid, busy, sel); n_fail++; end
        tick();
        req = 4'b1111;
        rst_n = 1'b1;
        tick();
        n_checks++; if (gnt !== 4'b0001) begin $display("FAIL mid_restart actual=%b expected=%b", gnt, 4'b0001); n_fail++; end
    endtask

    initial begin
        rst_n = 1'b0; req = 4'b0000; out_ready = 1'b0; in_data = 32'h0;
        test_reset_single();
        test_round_robin();
        test_backpressure();
        test_early_drop_and_wrap();
        test_reset_mid_grant();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
